// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 4-digit 7-segment driver with anti-ghosting guard,
// per-frame input snapshot (no tearing) and optional leading-zero blanking.
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   digit0_i..3_i  BCD digits, digit0 is the rightmost position
//   lz_blank_i     blank leading zeros on digit3/digit2
//   colon_en_i     light the decimal point of digit2 as a mm.ss separator
//   seg_o          active-low cathodes {g,f,e,d,c,b,a}
//   dp_o           active-low decimal-point cathode
//   an_o           active-low one-hot anodes, an_o[i] selects digit i
//   frame_done_o   one-cycle pulse following each input snapshot
module seg7_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    input  logic       lz_blank_i,
    input  logic       colon_en_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [3:0] an_o,
    output logic       frame_done_o
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          first_q;
    logic [15:0]   dig_q, dig_d;
    logic          lz_q, lz_d, colon_q, colon_d;
    logic [6:0]    seg_d, glyph;
    logic          dp_d, frame_done_d;
    logic [3:0]    an_d, cur;
    logic          wrap, snap, guard, blank;
    always_comb begin
        wrap         = slot_cnt_q == LAST;
        // first_q marks the first edge after reset: snapshot and hold slot 0 so the
        // scan restarts in the guard phase of index 0
        snap         = first_q || (wrap && idx_q == 2'd3);
        slot_cnt_d   = (first_q || wrap) ? '0 : slot_cnt_q + CW'(1);
        idx_d        = first_q ? 2'd0 : (wrap ? idx_q + 2'd1 : idx_q);
        dig_d        = snap ? {digit3_i, digit2_i, digit1_i, digit0_i} : dig_q;
        lz_d         = snap ? lz_blank_i : lz_q;
        colon_d      = snap ? colon_en_i : colon_q;
        frame_done_d = snap;
        cur          = dig_d[{idx_d, 2'b00} +: 4];
        guard        = slot_cnt_d < GUARD_C;
        blank        = lz_d && ((idx_d == 2'd3 && dig_d[15:12] == 4'd0) ||
                                (idx_d == 2'd2 && dig_d[15:8] == 8'd0));
        case (cur)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
        seg_d = (guard || blank) ? 7'h7F : glyph;
        an_d  = guard ? 4'hF : ~(4'b0001 << idx_d);
        dp_d  = guard || idx_d != 2'd2 || !colon_d;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_cnt_q   <= '0;
            idx_q        <= 2'd0;
            first_q      <= 1'b1;
            dig_q        <= 16'd0;
            lz_q         <= 1'b0;
            colon_q      <= 1'b0;
            seg_o        <= 7'h7F;
            dp_o         <= 1'b1;
            an_o         <= 4'hF;
            frame_done_o <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            first_q      <= 1'b0;
            dig_q        <= dig_d;
            lz_q         <= lz_d;
            colon_q      <= colon_d;
            seg_o        <= seg_d;
            dp_o         <= dp_d;
            an_o         <= an_d;
            frame_done_o <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: randomized scoreboard bench for seg7_scanner (REFRESH_DIV=4, GUARD=1).
module tb_seg7_scanner;
    localparam int DIV = 4;
    localparam int G   = 1;
    localparam int FRAME = 4 * DIV;
    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;
    logic       clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1;
    logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
    logic       lz = 1'b0, colon = 1'b0;
    logic [6:0] seg;
    logic       dp, frame_done;
    logic [3:0] an;
    logic [3:0] nd [4];
    logic       nlz, ncol, nrst;
    logic [3:0] sh [4];
    logic       lz_s, col_s;
    int         t = 0;
    int         checks = 0, failures = 0;
    exp_t       q[$];
    exp_t       mon_e;
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    seg7_scanner #(.REFRESH_DIV(DIV), .GUARD(G)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .digit0_i(digit0), .digit1_i(digit1), .digit2_i(digit2), .digit3_i(digit3),
        .lz_blank_i(lz), .colon_en_i(colon),
        .seg_o(seg), .dp_o(dp), .an_o(an), .frame_done_o(frame_done)
    );
    always #5 if (clk_en) clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want, input int tt);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", name, tt, act, want);
        end
    endtask
    task automatic check_idle(input string tag);
        chk({tag, "_an"}, an, 4'hF, -1);
        chk({tag, "_seg"}, seg, 7'h7F, -1);
        chk({tag, "_dp"}, dp, 1'b1, -1);
        chk({tag, "_fd"}, frame_done, 1'b0, -1);
    endtask
    // Expected display at time tt cycles after the first post-reset edge,
    // derived from frame position: 16-cycle frame, 4-cycle slots, first G cycles dark.
    function automatic exp_t model(input int tt);
        exp_t e;
        int pos, slot;
        logic blank;
        pos  = tt % FRAME;
        slot = pos / DIV;
        e.t  = tt;
        e.fd = (pos == 0);
        if (pos % DIV < G) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            e.an = 4'hF;
            e.an[slot] = 1'b0;
            blank = lz_s && ((slot == 3 && sh[3] == 4'd0) ||
                             (slot == 2 && sh[3] == 4'd0 && sh[2] == 4'd0));
            e.seg = blank ? 7'h7F : tbl[sh[slot]];
            e.dp  = !(slot == 2 && col_s);
        end
        return e;
    endfunction
    task automatic step();
        exp_t e;
        @(negedge clk);
        digit0 = nd[0]; digit1 = nd[1]; digit2 = nd[2]; digit3 = nd[3];
        lz = nlz; colon = ncol;
        if (!nrst) begin
            if (rst_n) begin
                rst_n = 1'b0;
                #1 check_idle("async_rst");
            end
            t = 0;
            e.t = -1; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
            q.push_back(e);
        end else begin
            rst_n = 1'b1;
            if (t % FRAME == 0) begin
                sh = nd; lz_s = nlz; col_s = ncol;
            end
            q.push_back(model(t));
            t++;
        end
    endtask
    task automatic rand_inputs();
        for (int i = 0; i < 4; i++)
            nd[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        nlz  = 1'($urandom_range(0, 1));
        ncol = 1'($urandom_range(0, 1));
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("an", an, mon_e.an, mon_e.t);
            chk("seg", seg, mon_e.seg, mon_e.t);
            chk("dp", dp, mon_e.dp, mon_e.t);
            chk("frame_done", frame_done, mon_e.fd, mon_e.t);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end
    initial begin
        nrst = 1'b0; nlz = 1'b0; ncol = 1'b0;
        nd[0] = 4'd7; nd[1] = 4'd8; nd[2] = 4'd9; nd[3] = 4'd6;
        #1 rst_n = 1'b0;
        #2 check_idle("stopped_rst");
        digit0 = 4'd3; colon = 1'b1; lz = 1'b1;
        #2 check_idle("stopped_rst_inchg");
        nd[0] = 4'd4; nd[1] = 4'd3; nd[2] = 4'd2; nd[3] = 4'd1;
        nlz = 1'b0; ncol = 1'b0;
        clk_en = 1'b1;
        repeat (2) step();
        nrst = 1'b1;
        repeat (40) step();
        while (t % FRAME != 6) step();
        nd[0] = 4'd9;
        repeat (30) step();
        nlz = 1'b1;
        nd[3] = 4'd0; nd[2] = 4'd0; nd[1] = 4'd0; nd[0] = 4'd5;
        repeat (32) step();
        nd[3] = 4'd0; nd[2] = 4'd7; nd[1] = 4'd0; nd[0] = 4'd0;
        repeat (32) step();
        nlz = 1'b0; ncol = 1'b1; nd[2] = 4'hA;
        repeat (32) step();
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) rand_inputs();
            step();
        end
        while (!((t % FRAME) / DIV == 2 && t % DIV == 2)) step();
        nrst = 1'b0;
        repeat (3) step();
        nrst = 1'b1;
        repeat (40) step();
        @(posedge clk);
        #2 chk("queue_drained", q.size(), 0, t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter GUARD, default 16: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 .. REFRESH_DIV-1.
REQ-003 clk  in  1  system clock (100 MHz on board).
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 digit0..digit3  in  4 each  BCD digits from the stopwatch; digit0 is the rightmost display position.
REQ-006 lz_blank  in  1  1 = blank leading zeros on digit3/digit2.
REQ-007 colon_en  in  1  1 = light the decimal point on digit2 as a mm.ss separator.
REQ-008 seg  out  7  cathodes, active-low, bit order seg[6:0] = g,f,e,d,c,b,a.
REQ-009 dp  out  1  decimal-point cathode, active-low.
REQ-010 an  out  4  anodes, active-low one-hot; an[i] selects digit i.
REQ-011 frame_done  out  1  one-cycle pulse after each input snapshot.

Function
REQ-012 The block shall hold slot_cnt (0..REFRESH_DIV-1, wraps to 0) and a 2-bit scan index; the index shall advance 0->1->2->3->0 on each slot_cnt wrap.
REQ-013 Each slot shall have two phases: GUARD while slot_cnt < GUARD (an=4'b1111, seg=7'h7F, dp=1), then DRIVE for the rest of the slot (an[index]=0, all other anodes 1).
REQ-014 A snapshot shall copy digit0..3, lz_blank and colon_en into shadow registers on the edge where slot_cnt==REFRESH_DIV-1 and index==3, and on the first rising edge after reset deassertion.
REQ-015 seg, dp and an shall be driven only from shadow registers; input changes between snapshots shall not affect the display (no tearing).
REQ-016 frame_done shall be 1 for exactly the one cycle following each snapshot edge, 0 otherwise; the frame period is 4*REFRESH_DIV cycles.
REQ-017 All outputs shall be registers, decoded from the next-state slot_cnt/index/shadow values so that they reflect the current slot with no additional latency.
REQ-018 Decode (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; non-BCD values A-F shall show a dash, 3F.
REQ-019 With shadow lz_blank=1: digit3 shall be blanked (seg=7F) when it is 0; digit2 shall be blanked when digit3 and digit2 are both 0; digit1 and digit0 shall never be blanked; the anode shall still be driven in a blanked slot.
REQ-020 dp shall be 0 only in the DRIVE phase of index 2 with shadow colon_en=1; otherwise 1.
REQ-021 With GUARD=0 there shall be no GUARD phase; DRIVE shall cover the whole slot.

Reset
REQ-022 reset=0 shall immediately, without a clock edge, force an=4'b1111, seg=7'h7F, dp=1, frame_done=0, slot_cnt=0, index=0 and all shadow registers to 0.
REQ-023 Reset asserted mid-frame shall abort the scan; after release, scanning shall restart at index 0 (GUARD phase) with a fresh snapshot per REQ-014.
REQ-024 No output shall glitch active while reset is held low.

Verification (REFRESH_DIV=4, GUARD=1)
REQ-025 Hold reset=0 with clk stopped -> an=1111, seg=7F, dp=1, frame_done=0.
REQ-026 digit3..0=1,2,3,4, release reset -> per slot 1 cycle an=1111 then 3 cycles driven: an=1110/seg=19, an=1101/seg=30, an=1011/seg=24, an=0111/seg=79; frame_done every 16 cycles.
REQ-027 Change digit0 from 4 to 9 at mid-frame -> slot 0 keeps showing 19 until the next frame_done, then shows 10.
REQ-028 lz_blank=1, digits 0,0,0,5 -> slots 3 and 2 seg=7F, slot 1 seg=40, slot 0 seg=12; digits 0,7,0,0 -> slot 3 seg=7F, slot 2 seg=78.
REQ-029 colon_en=1, digit2=4'hA -> dp=0 only during the 3 DRIVE cycles of slot 2, seg=3F there; dp=1 in all other cycles.
REQ-030 Pulse reset=0 during slot 2 -> outputs go idle immediately; after release, the scan restarts at slot 0 and frame_done pulses one cycle after the first edge.
